// File: rtl/pattern_capture_if.sv
// Write-side bundle between pattern_capture and the capture FIFO.
// The capture block is master: it presents data and a write strobe.
interface pattern_capture_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_to_fifo;
    logic             fifo_wr_req;
    logic             fifo_full;

    modport master (
        output data_to_fifo,
        output fifo_wr_req,
        input  fifo_full
    );

    modport slave (
        input  data_to_fifo,
        input  fifo_wr_req,
        output fifo_full
    );
endinterface

// File: rtl/pattern_capture.sv
// Triggered pattern sampler: arms on a start edge, waits for a masked match,
// then pushes one sample every sample_speed+1 cycles into the capture FIFO.
module pattern_capture #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture_control,
    input  logic                 capture_abort,
    input  logic [15:0]          sample_speed,
    input  logic [15:0]          capture_length,
    input  logic [WIDTH-1:0]     trigger_mask,
    input  logic [WIDTH-1:0]     trigger_value,
    input  logic [WIDTH-1:0]     pattern_in,
    pattern_capture_if.master    fifo,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURING,
        DONE
    } state_t;

    state_t      state;
    logic        ctrl_d;
    logic [15:0] period_cnt;
    logic [15:0] sample_cnt;
    logic [15:0] sample_next;
    logic        start;
    logic        match;
    logic        slot;
    logic        last;

    assign start       = capture_control & ~ctrl_d;
    assign match       = ((pattern_in ^ trigger_value) & trigger_mask) == '0;
    assign sample_next = sample_cnt + 16'd1;
    assign last        = sample_next == capture_length;

    // The trigger cycle itself is the first slot; later slots come off period_cnt.
    always_comb begin
        slot = 1'b0;
        if (!capture_abort) begin
            if (state == ARMED)
                slot = match;
            else if (state == CAPTURING)
                slot = period_cnt == sample_speed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            ctrl_d            <= 1'b1;
            period_cnt        <= '0;
            sample_cnt        <= '0;
            fifo.data_to_fifo <= '0;
            fifo.fifo_wr_req  <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            ctrl_d           <= capture_control;
            fifo.fifo_wr_req <= 1'b0;
            done             <= 1'b0;

            if (capture_abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            overflow   <= 1'b0;
                            sample_cnt <= '0;
                            period_cnt <= '0;
                            if (capture_length == 16'd0) begin
                                state <= DONE;
                            end else begin
                                state <= ARMED;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (match) begin
                            state <= last ? DONE : CAPTURING;
                            busy  <= ~last;
                        end
                    end
                    CAPTURING: begin
                        if (period_cnt == sample_speed) begin
                            period_cnt <= '0;
                            if (last) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            period_cnt <= period_cnt + 16'd1;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            // A full FIFO still consumes the slot; only the write is lost.
            if (slot) begin
                sample_cnt <= sample_next;
                if (fifo.fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    fifo.data_to_fifo <= pattern_in;
                    fifo.fifo_wr_req  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_capture.sv
// Scoreboard bench for pattern_capture: a slot-list reference model queues
// expected writes and done pulses, and a monitor pops them as the DUT strobes.
module tb_pattern_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_control = 1'b1;
    logic        capture_abort = 1'b0;
    logic [15:0] sample_speed = '0;
    logic [15:0] capture_length = '0;
    logic [15:0] trigger_mask = '0;
    logic [15:0] trigger_value = '0;
    logic [15:0] pattern_in = '0;
    logic        busy;
    logic        done;
    logic        overflow;

    pattern_capture_if #(.WIDTH(16)) fifo_bus ();

    pattern_capture #(.WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .capture_control (capture_control),
        .capture_abort   (capture_abort),
        .sample_speed    (sample_speed),
        .capture_length  (capture_length),
        .trigger_mask    (trigger_mask),
        .trigger_value   (trigger_value),
        .pattern_in      (pattern_in),
        .fifo            (fifo_bus),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    logic [15:0] pat_mem[int];
    bit          full_mem[int];
    int          ecount = 0;
    int          abort_edge = -1;
    int          rst_edge = -1;
    bit          rst_hold = 1'b1;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) ecount++;

    // Inputs for edge ecount+1 are presented on the preceding falling edge.
    always @(negedge clk) begin
        pattern_in = pat_mem.exists(ecount + 1) ? pat_mem[ecount + 1] : 16'h0;
        fifo_bus.fifo_full = full_mem.exists(ecount + 1) ? full_mem[ecount + 1] : 1'b0;
        capture_abort = (ecount + 1 == abort_edge);
        rst = rst_hold || (ecount + 1 == rst_edge);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, ecount, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_bus.fifo_wr_req === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected at edge %0d: data %h, expected no write",
                         ecount, fifo_bus.data_to_fifo);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                if (w.cyc != ecount || w.data !== fifo_bus.data_to_fifo) begin
                    failures++;
                    $display("FAIL wr_data: got %h at edge %0d, expected %h at edge %0d",
                             fifo_bus.data_to_fifo, ecount, w.data, w.cyc);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_done.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected at edge %0d: got 1, expected 0", ecount);
            end else begin
                int d;
                d = exp_done.pop_front();
                if (d != ecount) begin
                    failures++;
                    $display("FAIL done_cycle: got edge %0d, expected edge %0d", ecount, d);
                end
            end
        end
    end

    task automatic run(input int speed, input int len,
                       input logic [15:0] mask, input logic [15:0] val,
                       input int pmode, input int trig_off,
                       input int full_pct, input int full_off,
                       input int abort_off, input int rst_off);
        int  s;
        int  t;
        int  kill;
        int  slot_e;
        int  end_e;
        bit  ovf;
        wr_t w;
        @(negedge clk);
        s = ecount + 1;
        for (int i = 1; i <= 300; i++) begin
            case (pmode)
                1:       pat_mem[s + i] = 16'(i - 1);
                2:       pat_mem[s + i] = (i <= 10) ? 16'h0000 : 16'h1242;
                default: pat_mem[s + i] = 16'($urandom);
            endcase
            full_mem[s + i] = ($urandom_range(0, 99) < full_pct);
        end
        if (pmode == 0)
            pat_mem[s + trig_off] = (16'($urandom) & ~mask) | (val & mask);
        if (full_off > 0)
            full_mem[s + full_off] = 1'b1;
        abort_edge = (abort_off > 0) ? s + abort_off : -1;
        rst_edge   = (rst_off > 0) ? s + rst_off : -1;
        kill = 1 << 30;
        if (abort_edge > 0 && abort_edge < kill) kill = abort_edge;
        if (rst_edge > 0 && rst_edge < kill) kill = rst_edge;
        sample_speed    = 16'(speed);
        capture_length  = 16'(len);
        trigger_mask    = mask;
        trigger_value   = val;
        capture_control = 1'b1;

        // Reference: slots at t, t+P, t+2P ... for the first matching edge t.
        ovf   = 1'b0;
        end_e = s + 1;
        if (len == 0) begin
            if (s + 1 < kill) exp_done.push_back(s + 1);
        end else begin
            t = 0;
            for (int e = s + 1; e <= s + 300 && t == 0; e++)
                if (((pat_mem[e] ^ val) & mask) == 16'h0) t = e;
            slot_e = t;
            for (int k = 0; k < len; k++) begin
                slot_e = t + k * (speed + 1);
                if (slot_e < kill) begin
                    if (full_mem[slot_e]) begin
                        ovf = 1'b1;
                    end else begin
                        w.cyc  = slot_e;
                        w.data = pat_mem[slot_e];
                        exp_wr.push_back(w);
                    end
                end
            end
            if (slot_e + 1 < kill) exp_done.push_back(slot_e + 1);
            end_e = slot_e + 1;
        end
        if (abort_edge > end_e) end_e = abort_edge;
        if (rst_edge > end_e) end_e = rst_edge;

        while (ecount < end_e + 3) begin
            @(negedge clk);
            if (ecount == s) begin
                capture_control = 1'b0;
                chk("busy_after_start", int'(busy), (len != 0) ? 1 : 0);
                chk("overflow_cleared", int'(overflow), 0);
            end
            if (ecount == abort_edge)
                chk("busy_after_abort", int'(busy), 0);
            if (ecount == rst_edge) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_wr", int'(fifo_bus.fifo_wr_req), 0);
                chk("rst_data", int'(fifo_bus.data_to_fifo), 0);
                chk("rst_overflow", int'(overflow), 0);
            end
        end
        chk("missing_writes", exp_wr.size(), 0);
        chk("missing_done", exp_done.size(), 0);
        chk("overflow_end", int'(overflow), (rst_edge > 0) ? 0 : int'(ovf));
        chk("busy_end", int'(busy), 0);
        exp_wr.delete();
        exp_done.delete();
        abort_edge = -1;
        rst_edge   = -1;
        pat_mem.delete();
        full_mem.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_wr", int'(fifo_bus.fifo_wr_req), 0);
        chk("reset_data", int'(fifo_bus.data_to_fifo), 0);
        rst_hold = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_start_level_high", int'(busy), 0);
        capture_control = 1'b0;
        @(negedge clk);

        // Zero-length capture: done only, no writes.
        run(0, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0, 0);
        // Mask 0, counting pattern: writes 0,3,6,9.
        run(2, 4, 16'h0, 16'h0, 1, 1, 0, 0, 0, 0);
        // Masked trigger after ten idle cycles.
        run(1, 3, 16'h00FF, 16'h0042, 2, 1, 0, 0, 0, 0);
        // FIFO full on slot 2 of 4.
        run(0, 4, 16'h0, 16'h0, 1, 1, 0, 2, 0, 0);
        // Abort after two writes, then re-arm.
        run(1, 6, 16'h0, 16'h0, 1, 1, 0, 0, 4, 0);
        run(1, 2, 16'h0, 16'h0, 1, 1, 0, 0, 0, 0);
        // Reset mid-capture.
        run(0, 8, 16'h0, 16'h0, 1, 1, 0, 0, 0, 4);
        // Maximal single slot and long period.
        run(5, 1, 16'hF00F, 16'hA005, 0, 7, 0, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            int ab;
            int rs;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            rs = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : 0;
            run($urandom_range(0, 3), $urandom_range(0, 6),
                16'($urandom) & 16'($urandom) & 16'($urandom), 16'($urandom),
                0, $urandom_range(1, 15),
                ($urandom_range(0, 1) == 1) ? 30 : 0, 0, ab, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
